// File: rtl/etapa_wb_pkg.sv
// rtl/etapa_wb_pkg.sv - shared write-back encodings and default geometry
//   WB_SRC_*       : sel_wb encodings shared with the decoder and the MEM stage
//   WB_*_DEF       : default element width, register address width and lane count
//   WB_IMM_W       : width of the immediate field carried down the pipe
package etapa_wb_pkg;

  localparam int WB_DATA_W_DEF = 32;
  localparam int WB_ADDR_W_DEF = 3;
  localparam int WB_LANES_DEF  = 4;
  localparam int WB_IMM_W      = 8;

  // 11 is reserved and decodes like WB_SRC_DATA.
  typedef enum logic [1:0] {
    WB_SRC_DATA = 2'b00,
    WB_SRC_MEM  = 2'b01,
    WB_SRC_IMM  = 2'b10,
    WB_SRC_RSVD = 2'b11
  } wb_src_e;

endpackage

// File: rtl/etapa_wb_registro_memwb.sv
// rtl/etapa_wb_registro_memwb.sv - MEM/WB stage register with synchronous active-low clear
//   clk, rst_n                 : clock, synchronous active-low clear
//   wb_en, sel_wb, dir_dest_in : control captured from the MEM stage
//   data_in, inmediate_in      : data captured from the MEM stage
//   en_q, sel_q, dest_q,
//   data_q, imm_q              : registered copies, no enable
import etapa_wb_pkg::*;

module registro_MEMWB #(
  parameter int DATA_W = WB_DATA_W_DEF,
  parameter int ADDR_W = WB_ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_en,
  input  logic [1:0]          sel_wb,
  input  logic [ADDR_W-1:0]   dir_dest_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [WB_IMM_W-1:0] inmediate_in,
  output logic                en_q,
  output logic [1:0]          sel_q,
  output logic [ADDR_W-1:0]   dest_q,
  output logic [DATA_W-1:0]   data_q,
  output logic [WB_IMM_W-1:0] imm_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      sel_q  <= WB_SRC_DATA;
      dest_q <= '0;
      data_q <= '0;
      imm_q  <= '0;
    end else begin
      en_q   <= wb_en;
      sel_q  <= sel_wb;
      dest_q <= dir_dest_in;
      data_q <= data_in;
      imm_q  <= inmediate_in;
    end
  end

endmodule

// File: rtl/etapa_wb.sv
// rtl/etapa_wb.sv - write-back stage: MEM/WB register, source mux, vector-load lane sequencer
//   clk, rst_n          : clock, synchronous active-low reset
//   data_in, mem_q      : ALU/data path value, RAM read data (valid in the write cycle)
//   inmediate_in        : 8-bit immediate, zero-extended when selected
//   dir_dest_in, wb_en,
//   sel_wb, vload       : beat control from the MEM stage
//   wr_en, wr_addr,
//   wr_lane, wr_data    : register-file write port
//   vec_done, seq_err   : pulses on final lane write / aborted vector load
//   busy                : vector load in progress
//   Optional macro WB_FWD_EN adds fwd_valid/fwd_addr/fwd_lane/fwd_data mirrors of the write port.
import etapa_wb_pkg::*;

module etapa_wb #(
  parameter int  DATA_W = WB_DATA_W_DEF,
  parameter int  ADDR_W = WB_ADDR_W_DEF,
  parameter int  LANES  = WB_LANES_DEF,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [DATA_W-1:0]   mem_q,
  input  logic [WB_IMM_W-1:0] inmediate_in,
  input  logic [ADDR_W-1:0]   dir_dest_in,
  input  logic                wb_en,
  input  logic [1:0]          sel_wb,
  input  logic                vload,
`ifdef WB_FWD_EN
  output logic                fwd_valid,
  output logic [ADDR_W-1:0]   fwd_addr,
  output logic [LANE_W-1:0]   fwd_lane,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [LANE_W-1:0]   wr_lane,
  output logic [DATA_W-1:0]   wr_data,
  output logic                vec_done,
  output logic                seq_err,
  output logic                busy
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [1:0]          sel_q;
  logic [DATA_W-1:0]   data_q;
  logic [WB_IMM_W-1:0] imm_q;

  registro_MEMWB #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_registro_memwb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_en        (wb_en),
    .sel_wb       (sel_wb),
    .dir_dest_in  (dir_dest_in),
    .data_in      (data_in),
    .inmediate_in (inmediate_in),
    .en_q         (wr_en),
    .sel_q        (sel_q),
    .dest_q       (wr_addr),
    .data_q       (data_q),
    .imm_q        (imm_q)
  );

  // mem_q is the RAM's own registered read, so it is used unregistered here.
  always_comb begin
    wr_data = data_q;
    case (sel_q)
      WB_SRC_MEM: wr_data = mem_q;
      WB_SRC_IMM: wr_data = {{(DATA_W - WB_IMM_W){1'b0}}, imm_q};
      default:    wr_data = data_q;
    endcase
  end

  // The lane counter is the sequencer state: zero is idle, nonzero is mid-load.
  // vload is consumed here at capture time, so lane and pulses are registered
  // off the same edge as the stage register and line up with wr_en.
  logic [LANE_W-1:0] lane_cnt;
  logic [ADDR_W-1:0] load_dest;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_cnt  <= '0;
      load_dest <= '0;
      wr_lane   <= '0;
      vec_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      wr_lane  <= '0;
      vec_done <= 1'b0;
      seq_err  <= 1'b0;
      if (wb_en) begin
        if (vload) begin
          load_dest <= dir_dest_in;
          if ((lane_cnt != '0) && (dir_dest_in != load_dest)) begin
            // New destination mid-load: this beat starts a fresh vector.
            seq_err  <= 1'b1;
            lane_cnt <= LANE_W'(1);
          end else begin
            wr_lane <= lane_cnt;
            if (lane_cnt == LAST_LANE) begin
              lane_cnt <= '0;
              vec_done <= 1'b1;
            end else begin
              lane_cnt <= lane_cnt + LANE_W'(1);
            end
          end
        end else begin
          // Scalar beat; it aborts any partial vector load.
          seq_err  <= (lane_cnt != '0);
          lane_cnt <= '0;
        end
      end
    end
  end

  assign busy = (lane_cnt != '0);

`ifdef WB_FWD_EN
  assign fwd_valid = wr_en;
  assign fwd_addr  = wr_addr;
  assign fwd_lane  = wr_lane;
  assign fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_etapa_wb.sv
// tb/tb_etapa_wb.sv - scoreboard bench for the write-back stage
module tb_etapa_wb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] mem_q = '0;
  logic [7:0]        inmediate_in = '0;
  logic [ADDR_W-1:0] dir_dest_in = '0;
  logic              wb_en = 1'b0;
  logic [1:0]        sel_wb = 2'b00;
  logic              vload = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANE_W-1:0] wr_lane;
  logic [DATA_W-1:0] wr_data;
  logic              vec_done;
  logic              seq_err;
  logic              busy;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [LANE_W-1:0] fwd_lane;
  logic [DATA_W-1:0] fwd_data;
`endif

  etapa_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .mem_q        (mem_q),
    .inmediate_in (inmediate_in),
    .dir_dest_in  (dir_dest_in),
    .wb_en        (wb_en),
    .sel_wb       (sel_wb),
    .vload        (vload),
`ifdef WB_FWD_EN
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_lane     (fwd_lane),
    .fwd_data     (fwd_data),
`endif
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_lane      (wr_lane),
    .wr_data      (wr_data),
    .vec_done     (vec_done),
    .seq_err      (seq_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] data;
    logic              done;
    logic              err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DATA_W-1:0] model_data(input logic [1:0] s, input logic [DATA_W-1:0] din,
                                                   input logic [7:0] imm, input logic [DATA_W-1:0] mq);
    case (s)
      2'b01:   return mq;
      2'b10:   return {24'h0, imm};
      default: return din;
    endcase
  endfunction

  // Scoreboard: every issued write is popped and compared; idle cycles must be pulse-free.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d lane=%0d data=%h, required no write", wr_addr, wr_lane, wr_data);
      end else begin
        e = sb.pop_front();
        if ({wr_addr, wr_lane, wr_data, vec_done, seq_err} !== {e.addr, e.lane, e.data, e.done, e.err}) begin
          errors++;
          $display("FAIL write_beat: got addr=%0d lane=%0d data=%h done=%b err=%b, required addr=%0d lane=%0d data=%h done=%b err=%b",
                   wr_addr, wr_lane, wr_data, vec_done, seq_err, e.addr, e.lane, e.data, e.done, e.err);
        end
      end
`ifdef WB_FWD_EN
      checks++;
      if ({fwd_valid, fwd_addr, fwd_lane, fwd_data} !== {wr_en, wr_addr, wr_lane, wr_data}) begin
        errors++;
        $display("FAIL fwd_mirror: got %b/%0d/%0d/%h", fwd_valid, fwd_addr, fwd_lane, fwd_data);
      end
`endif
    end else if (wr_en === 1'b0) begin
      checks++;
      if (vec_done !== 1'b0 || seq_err !== 1'b0) begin
        errors++;
        $display("FAIL stray_pulse: done=%b err=%b without wr_en, required 0 0", vec_done, seq_err);
      end
    end
  end

  // One beat sampled at the next edge; mem_q is presented in the following (write) cycle.
  task automatic drive_beat(input logic v, input logic [1:0] s, input logic [ADDR_W-1:0] d,
                            input logic [DATA_W-1:0] din, input logic [7:0] imm, input logic [DATA_W-1:0] mq,
                            input logic [LANE_W-1:0] lane, input logic done, input logic err);
    exp_t x;
    wb_en = 1'b1; vload = v; sel_wb = s; dir_dest_in = d; data_in = din; inmediate_in = imm;
    x.addr = d; x.lane = lane; x.data = model_data(s, din, imm, mq); x.done = done; x.err = err;
    sb.push_back(x);
    @(posedge clk); #1;
    mem_q = mq; wb_en = 1'b0; vload = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic check_busy(input string name, input logic exp);
    checks++;
    if (busy !== exp) begin
      errors++;
      $display("FAIL %s: busy=%b, required %b", name, busy, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_en = 1'b1; sel_wb = 2'b00; data_in = 32'h11; dir_dest_in = 3'd1;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({wr_en, busy, vec_done, seq_err} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_state: wr_en=%b busy=%b done=%b err=%b, required all 0", wr_en, busy, vec_done, seq_err);
      end
    end
    rst_n = 1'b1;
    drive_beat(1'b0, 2'b00, 3'd1, 32'h11, 8'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL first_write_latency: wr_en=%b, required 1", wr_en);
    end
  endtask

  task automatic test_scalar();
    drive_beat(1'b0, 2'b00, 3'd5, 32'hDEADBEEF, 8'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    check_busy("scalar_busy", 1'b0);
  endtask

  task automatic test_sources();
    drive_beat(1'b0, 2'b10, 3'd6, 32'hFFFF0000, 8'hA5, 32'h0, 2'd0, 1'b0, 1'b0);
    drive_beat(1'b0, 2'b01, 3'd7, 32'hFFFF0000, 8'h5A, 32'h12345678, 2'd0, 1'b0, 1'b0);
    drive_beat(1'b0, 2'b11, 3'd1, 32'hCAFEF00D, 8'h77, 32'h9999, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_vector_load();
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'd1, 2'd0, 1'b0, 1'b0);
    check_busy("vload_busy_beat1", 1'b1);
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'd2, 2'd1, 1'b0, 1'b0);
    idle_cycle();
    check_busy("vload_busy_gap", 1'b1);
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'd3, 2'd2, 1'b0, 1'b0);
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'd4, 2'd3, 1'b1, 1'b0);
    check_busy("vload_busy_done", 1'b0);
  endtask

  task automatic test_abort();
    drive_beat(1'b1, 2'b00, 3'd3, 32'h30, 8'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    drive_beat(1'b1, 2'b00, 3'd3, 32'h31, 8'h0, 32'h0, 2'd1, 1'b0, 1'b0);
    drive_beat(1'b0, 2'b00, 3'd3, 32'h33, 8'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    check_busy("abort_busy", 1'b0);
  endtask

  task automatic test_dest_change();
    drive_beat(1'b1, 2'b00, 3'd4, 32'h40, 8'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    drive_beat(1'b1, 2'b00, 3'd5, 32'h50, 8'h0, 32'h0, 2'd0, 1'b0, 1'b1);
    check_busy("dest_change_busy", 1'b1);
    for (int i = 1; i < LANES; i++)
      drive_beat(1'b1, 2'b00, 3'd5, 32'h50 + i, 8'h0, 32'h0, LANE_W'(i), (i == LANES - 1), 1'b0);
    check_busy("dest_change_done", 1'b0);
  endtask

  task automatic test_reset_midload();
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'hA0, 2'd0, 1'b0, 1'b0);
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'hA1, 2'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle_cycle();
    check_busy("midload_reset_busy", 1'b0);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset_wr_en: wr_en=%b, required 0", wr_en);
    end
    rst_n = 1'b1;
    drive_beat(1'b1, 2'b01, 3'd2, 32'h0, 8'h0, 32'hA2, 2'd0, 1'b0, 1'b0);
    check_busy("midload_restart_busy", 1'b1);
    drive_beat(1'b0, 2'b00, 3'd0, 32'hB0, 8'h0, 32'h0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < LANES; i++)
      drive_beat(1'b1, 2'b00, 3'd0, 32'h100 + i, 8'h0, 32'h0, LANE_W'(i), (i == LANES - 1), 1'b0);
    drive_beat(1'b0, 2'b10, 3'd7, 32'h0, 8'hFF, 32'h0, 2'd0, 1'b0, 1'b0);
    repeat (3) idle_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d writes outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_sources();
    test_vector_load();
    test_abort();
    test_dest_change();
    test_reset_midload();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
